cache_mem_arbiter: RTL
======================

# cache_mem_arbiter

Shares the single unified main memory (16-bit address/data, fixed 4-cycle read latency, pipelined) between the I-cache fill FSM, the D-cache fill FSM and D-cache write-through stores. Sits between the two cache controllers and the memory model. It grants one owner at a time and muxes that owner's address and enable onto the memory bus. It routes returning read data-valid to the owner. It holds the grant until the owner signals completion and all in-flight reads have drained.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- OUT_W, 3, width of outstanding-read counter (must hold MEM_LAT+1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  I-cache miss pending (level)
- i_rd  in  1  I-cache fill FSM issues a read this cycle
- i_addr  in  ADDR_W  I-cache fill read address
- i_done  in  1  I-cache fill complete (tag-write pulse)
- i_gnt  out  1  I-cache owns memory
- i_data_valid  out  1  mem_data_valid routed to I-cache
- d_req, d_rd, d_addr, d_done  in  1/1/ADDR_W/1  D-cache fill equivalents
- d_gnt, d_data_valid  out  1/1  D-cache equivalents
- d_wr_req  in  1  write-through store pending (level, held until ack)
- d_wr_addr  in  ADDR_W  store address
- d_wr_data  in  DATA_W  store data
- d_wr_ack  out  1  one-cycle pulse, store issued
- mem_addr  out  ADDR_W  memory address
- mem_data_in  out  DATA_W  memory write data
- mem_enable  out  1  memory access this cycle
- mem_wr  out  1  1 = write, 0 = read
- mem_data_valid  in  1  read data valid from memory
- protocol_err  out  1  sticky error flag

## Operation
- States: IDLE, WRITE, GNT_I, GNT_D, DRAIN. Register `owner` ∈ {NONE, I, D}. Register `last` ∈ {I, D}.
- IDLE: priority d_wr_req > fill requests.
  - d_wr_req → WRITE.
  - else exactly one of i_req/d_req → GNT_I/GNT_D.
  - both → grant the one ≠ `last`.
  - On a fill grant: set owner and update `last`.
- WRITE (one cycle): mem_enable=1, mem_wr=1, mem_addr=d_wr_addr, mem_data_in=d_wr_data, d_wr_ack=1 → IDLE.
- GNT_x:
  - mem_enable = x_rd, mem_wr=0, mem_addr = x_addr.
  - The other requester's rd/addr are ignored.
  - x_done with outstanding==0 (after this cycle's update) → IDLE, owner=NONE.
  - x_done with outstanding>0 → DRAIN.
- DRAIN: no new reads issued; the grant output stays high; when outstanding reaches 0 → IDLE, owner=NONE.
- Outstanding counter (OUT_W bits):
  - +1 on an issued read, −1 on mem_data_valid; both in one cycle → unchanged.
  - Decrement at 0 → hold 0, set protocol_err.
  - Increment at max → hold, set protocol_err.
- x_data_valid = mem_data_valid & (owner==x), combinational. mem_data_valid with owner==NONE → dropped, set protocol_err.
- x_done outside GNT_x ignored. d_wr_req while a fill is granted waits until IDLE.
- Outputs when not driven: mem_addr=0, mem_data_in=0, mem_enable=0, mem_wr=0.

## Timing
- Reset values: state=IDLE, owner=NONE, last=I (D wins first tie), outstanding=0, protocol_err=0, all grants/acks/mem outputs 0.
- rst is synchronous and active-high; it aborts any state, including mid-fill or DRAIN; late mem_data_valid after reset sets protocol_err.
- Request sampled in IDLE at edge t → grant high from cycle t+1. Minimum fill handover IDLE→GNT→IDLE→next GNT: 1 idle cycle between owners.
- Store latency: d_wr_req seen in IDLE at t → d_wr_ack and the memory write during cycle t+1.
- Grant outputs are registered (decoded from state); mem_* are combinational from state and owner inputs.
- Read data returns MEM_LAT=4 cycles after issue; the arbiter does not count latency, only outstanding reads.

## Structure
- Package mem_arb_pkg: state encoding, owner encoding, MEM_LAT=4, OUT_W default.
- Sub-module arb_outstanding_cnt: saturating up/down counter with zero/full flags and error outputs; instantiated once.
- Everything else (FSM, tie-break register, output mux) lives in cache_mem_arbiter.

## Test plan
- Reset: hold rst 2 cycles mid-GNT_D with outstanding=3 → next cycle state IDLE, d_gnt=0, outstanding=0, protocol_err=0; later mem_data_valid → protocol_err=1.
- Single I-fill: i_req at t → i_gnt at t+1; 8 reads at 0x1230..0x123E, mem_data_valid 4 cycles after each → 8 i_data_valid pulses, d_data_valid=0; i_done after the 8th → IDLE next cycle.
- Tie-break: i_req and d_req together after reset → D granted first; on D done, I granted after 1 idle cycle; repeat simultaneous → I then D (alternates).
- Early done: d_done while 2 reads are in flight → DRAIN, d_gnt stays 1, d_rd ignored; after 2 valids → IDLE.
- Store priority: d_wr_req (addr 0x0040, data 0xBEEF) with i_req pending in IDLE → write cycle with mem_wr=1 and matching addr/data, d_wr_ack one cycle, then i_gnt.
- Store during fill: d_wr_req asserted while GNT_I → no ack until after i_done and drain; then ack within 1 cycle of IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings and constants for the cache/main-memory arbiter.
package mem_arb_pkg;

  localparam int MEM_LAT   = 4;
  localparam int OUT_W_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_GNT_I,
    ST_GNT_D,
    ST_DRAIN
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_e;

  typedef enum logic {
    LAST_I,
    LAST_D
  } last_e;

endpackage

// File: rtl/arb_outstanding_cnt.sv
// Saturating up/down count of reads issued to memory but not yet returned.
module arb_outstanding_cnt #(
  parameter int W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic zero_next,
  output logic err_under,
  output logic err_over
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] count;
  logic [W-1:0] count_next;
  logic         zero;
  logic         full;

  assign zero = (count == '0);
  assign full = (count == MAX);

  // A simultaneous issue and return leaves the count untouched.
  always_comb begin
    count_next = count;
    err_under  = 1'b0;
    err_over   = 1'b0;
    if (inc && !dec) begin
      if (full) err_over = 1'b1;
      else      count_next = count + 1'b1;
    end else if (dec && !inc) begin
      if (zero) err_under = 1'b1;
      else      count_next = count - 1'b1;
    end
  end

  assign zero_next = (count_next == '0);

  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= count_next;
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Grants the unified main memory to the I-fill, D-fill or write-through store
// path, muxes the owner onto the memory bus and routes read returns back.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner; picks store first, then fills (alternating ties)
// ST_WRITE | single-cycle write-through store on the memory bus
// ST_GNT_I | I-cache fill owns memory, its reads go to the bus
// ST_GNT_D | D-cache fill owns memory, its reads go to the bus
// ST_DRAIN | owner signalled done; waiting for in-flight reads to return
module cache_mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_rd,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_done,
  output logic              i_gnt,
  output logic              i_data_valid,
  input  logic              d_req,
  input  logic              d_rd,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_done,
  output logic              d_gnt,
  output logic              d_data_valid,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_enable,
  output logic              mem_wr,
  input  logic              mem_data_valid,
  output logic              protocol_err
);

  arb_state_e state, state_nxt;
  owner_e     owner, owner_nxt;
  last_e      last,  last_nxt;

  logic rd_issue;
  logic zero_next;
  logic err_under;
  logic err_over;
  logic stray_valid;

  assign rd_issue = ((state == ST_GNT_I) && i_rd) || ((state == ST_GNT_D) && d_rd);

  arb_outstanding_cnt #(.W(OUT_W)) u_out_cnt (
    .clk       (clk),
    .rst       (rst),
    .inc       (rd_issue),
    .dec       (mem_data_valid),
    .zero_next (zero_next),
    .err_under (err_under),
    .err_over  (err_over)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      owner <= OWN_NONE;
      last  <= LAST_I;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    last_nxt    = last;
    mem_addr    = '0;
    mem_data_in = '0;
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    d_wr_ack    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (d_wr_req) begin
          state_nxt = ST_WRITE;
        end else if (i_req && (!d_req || (last == LAST_D))) begin
          state_nxt = ST_GNT_I;
          owner_nxt = OWN_I;
          last_nxt  = LAST_I;
        end else if (d_req) begin
          state_nxt = ST_GNT_D;
          owner_nxt = OWN_D;
          last_nxt  = LAST_D;
        end
      end
      ST_WRITE: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = d_wr_addr;
        mem_data_in = d_wr_data;
        d_wr_ack    = 1'b1;
        state_nxt   = ST_IDLE;
      end
      ST_GNT_I: begin
        mem_addr   = i_addr;
        mem_enable = i_rd;
        if (i_done) begin
          if (zero_next) begin
            state_nxt = ST_IDLE;
            owner_nxt = OWN_NONE;
          end else begin
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_GNT_D: begin
        mem_addr   = d_addr;
        mem_enable = d_rd;
        if (d_done) begin
          if (zero_next) begin
            state_nxt = ST_IDLE;
            owner_nxt = OWN_NONE;
          end else begin
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (zero_next) begin
          state_nxt = ST_IDLE;
          owner_nxt = OWN_NONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        owner_nxt = OWN_NONE;
      end
    endcase
  end

  // Owner stays set through DRAIN, so the grant holds until the last return.
  assign i_gnt        = (owner == OWN_I);
  assign d_gnt        = (owner == OWN_D);
  assign i_data_valid = mem_data_valid && (owner == OWN_I);
  assign d_data_valid = mem_data_valid && (owner == OWN_D);
  assign stray_valid  = mem_data_valid && (owner == OWN_NONE);

  always_ff @(posedge clk) begin
    if (rst)                                   protocol_err <= 1'b0;
    else if (err_under || err_over || stray_valid) protocol_err <= 1'b1;
  end

endmodule
